// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester main-memory arbiter.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Two-way grant between instruction fetch and data memory requests.
// MEM_ARB_ROUND_ROBIN_EN: alternate on simultaneous requests; otherwise DM has fixed priority.
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic   clk,
  input  logic   reset,
  input  logic   enable,
`endif
  input  logic   if_req,
  input  logic   dm_req,
  output owner_t owner,
  output logic   valid
);

  assign valid = if_req | dm_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t last_q;

  // last_q remembers who was served last; the other side wins a tie
  always_comb begin
    owner = OWN_IF;
    if (if_req && dm_req) begin
      owner = (last_q == OWN_DM) ? OWN_IF : OWN_DM;
    end else if (dm_req) begin
      owner = OWN_DM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= OWN_IF;
    end else if (enable) begin
      last_q <= owner;
    end
  end
`else
  assign owner = dm_req ? OWN_DM : OWN_IF;
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Single-port main memory arbiter between instruction fetch and data access.
// Optional MEM_ARB_ROUND_ROBIN_EN switches tie-breaking from DM priority to round robin.
//
// state  | meaning
// IDLE   | sample requests, latch winner and its address/data/direction
// ACCESS | memory strobes held for WAIT_STATES+1 cycles, data sampled on the last
// RESP   | one-cycle ACK to the owner
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATAWIDTH_BUS = 32,
  parameter int WAIT_STATES   = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     IF_REQ,
  input  logic [DATAWIDTH_BUS-1:0] IF_ADDRESS,
  output logic [DATAWIDTH_BUS-1:0] IF_DATA_OUT,
  output logic                     IF_ACK,
  input  logic                     DM_REQ,
  input  logic                     DM_WR,
  input  logic [DATAWIDTH_BUS-1:0] DM_ADDRESS,
  input  logic [DATAWIDTH_BUS-1:0] DM_DATA_IN,
  output logic [DATAWIDTH_BUS-1:0] DM_DATA_OUT,
  output logic                     DM_ACK,
  output logic                     MEM_RD,
  output logic                     MEM_WR,
  output logic [DATAWIDTH_BUS-1:0] MEM_ADDRESS,
  output logic [DATAWIDTH_BUS-1:0] MEM_DATA_IN,
  input  logic [DATAWIDTH_BUS-1:0] MEM_DATA_OUT
);

  if (WAIT_STATES < 0 || WAIT_STATES > (1 << CNT_W) - 1) begin : g_bad_wait_states
    $error("memory_arbiter: WAIT_STATES must be within 0..15");
  end

  state_t             state_q, state_d;
  owner_t             owner_q, grant_owner;
  logic               grant_valid;
  logic [CNT_W-1:0]   cnt_q;
  logic               start, done, grant_wr;
  logic [DATAWIDTH_BUS-1:0] sel_addr;

  mem_arb_grant u_grant (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk    (CLK),
    .reset  (RESET),
    .enable (start),
`endif
    .if_req (IF_REQ),
    .dm_req (DM_REQ),
    .owner  (grant_owner),
    .valid  (grant_valid)
  );

  assign start    = (state_q == IDLE) && grant_valid;
  assign done     = (state_q == ACCESS) && (cnt_q == '0);
  assign grant_wr = (grant_owner == OWN_DM) && DM_WR;
  assign sel_addr = (grant_owner == OWN_DM) ? DM_ADDRESS : IF_ADDRESS;

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All outputs registered: strobes rise on entry to ACCESS, fall as ACK is raised
  always_ff @(posedge CLK) begin
    if (RESET) begin
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      MEM_RD      <= 1'b0;
      MEM_WR      <= 1'b0;
      MEM_ADDRESS <= '0;
      MEM_DATA_IN <= '0;
      IF_DATA_OUT <= '0;
      DM_DATA_OUT <= '0;
      IF_ACK      <= 1'b0;
      DM_ACK      <= 1'b0;
    end else begin
      IF_ACK <= 1'b0;
      DM_ACK <= 1'b0;
      if (start) begin
        owner_q     <= grant_owner;
        cnt_q       <= CNT_W'(WAIT_STATES);
        MEM_ADDRESS <= sel_addr & ~DATAWIDTH_BUS'(3);
        MEM_RD      <= ~grant_wr;
        MEM_WR      <= grant_wr;
        if (grant_owner == OWN_DM) MEM_DATA_IN <= DM_DATA_IN;
      end else if (done) begin
        MEM_RD <= 1'b0;
        MEM_WR <= 1'b0;
        if (owner_q == OWN_DM) begin
          DM_ACK <= 1'b1;
          if (!MEM_WR) DM_DATA_OUT <= MEM_DATA_OUT;
        end else begin
          IF_ACK      <= 1'b1;
          IF_DATA_OUT <= MEM_DATA_OUT;
        end
      end else if (state_q == ACCESS) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: one instance with WAIT_STATES=1, one with WAIT_STATES=0.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        if_req = 1'b0, dm_req = 1'b0, dm_wr = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_din = '0;
  logic [31:0] if_dout, dm_dout, mem_addr, mem_din, mem_dout;
  logic        if_ack, dm_ack, mem_rd, mem_wr;

  logic        if_req0 = 1'b0;
  logic [31:0] if_addr0 = '0;
  logic [31:0] if_dout0, dm_dout0, mem_addr0, mem_din0, mem_dout0;
  logic        if_ack0, dm_ack0, mem_rd0, mem_wr0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd2048: return 32'h8880200a;
      32'd2052: return 32'h86802000;
      32'd2056: return 32'h88813fff;
      32'd2060: return 32'h82802001;
      default:  return a ^ 32'hc0de0000;
    endcase
  endfunction

  assign mem_dout  = mem_word(mem_addr);
  assign mem_dout0 = mem_word(mem_addr0);

  memory_arbiter #(.DATAWIDTH_BUS(32), .WAIT_STATES(1)) dut (
    .CLK(clk), .RESET(rst),
    .IF_REQ(if_req), .IF_ADDRESS(if_addr), .IF_DATA_OUT(if_dout), .IF_ACK(if_ack),
    .DM_REQ(dm_req), .DM_WR(dm_wr), .DM_ADDRESS(dm_addr), .DM_DATA_IN(dm_din),
    .DM_DATA_OUT(dm_dout), .DM_ACK(dm_ack),
    .MEM_RD(mem_rd), .MEM_WR(mem_wr), .MEM_ADDRESS(mem_addr),
    .MEM_DATA_IN(mem_din), .MEM_DATA_OUT(mem_dout)
  );

  memory_arbiter #(.DATAWIDTH_BUS(32), .WAIT_STATES(0)) dut0 (
    .CLK(clk), .RESET(rst),
    .IF_REQ(if_req0), .IF_ADDRESS(if_addr0), .IF_DATA_OUT(if_dout0), .IF_ACK(if_ack0),
    .DM_REQ(1'b0), .DM_WR(1'b0), .DM_ADDRESS(32'd0), .DM_DATA_IN(32'd0),
    .DM_DATA_OUT(dm_dout0), .DM_ACK(dm_ack0),
    .MEM_RD(mem_rd0), .MEM_WR(mem_wr0), .MEM_ADDRESS(mem_addr0),
    .MEM_DATA_IN(mem_din0), .MEM_DATA_OUT(mem_dout0)
  );

  // Acks to the two requesters must never overlap
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((if_ack & dm_ack) !== 1'b0) begin
        errors++;
        $display("FAIL ack_exclusive: if_ack=%b dm_ack=%b required not both 1", if_ack, dm_ack);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_rd, mem_wr, if_ack, dm_ack} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 0000", {mem_rd, mem_wr, if_ack, dm_ack});
    end
    checks++;
    if ({mem_addr, mem_din, if_dout, dm_dout} !== 128'd0) begin
      errors++;
      $display("FAIL reset_buses: addr=%h din=%h if=%h dm=%h required all 0", mem_addr, mem_din, if_dout, dm_dout);
    end
    checks++;
    if ({mem_rd0, mem_wr0, if_ack0, dm_ack0, mem_din0, dm_dout0, if_dout0} !== 100'd0) begin
      errors++;
      $display("FAIL reset_ws0: outputs not zero, if_dout0=%h", if_dout0);
    end
    rst = 1'b0;
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_addr = 32'd2048;
    @(negedge clk);  // cycle 1
    checks++;
    if ({mem_rd, mem_wr} !== 2'b10 || mem_addr !== 32'd2048) begin
      errors++;
      $display("FAIL if_read_c1: rd/wr=%b addr=%0d required 10 / 2048", {mem_rd, mem_wr}, mem_addr);
    end
    @(negedge clk);  // cycle 2
    checks++;
    if (mem_rd !== 1'b1 || if_ack !== 1'b0) begin
      errors++;
      $display("FAIL if_read_c2: mem_rd=%b if_ack=%b required 1 0", mem_rd, if_ack);
    end
    @(negedge clk);  // cycle 3
    checks++;
    if (if_ack !== 1'b1 || dm_ack !== 1'b0 || mem_rd !== 1'b0 || if_dout !== 32'h8880200a) begin
      errors++;
      $display("FAIL if_read_ack: if_ack=%b dm_ack=%b rd=%b data=%h required 1 0 0 8880200a", if_ack, dm_ack, mem_rd, if_dout);
    end
    if_req = 1'b0;
    @(negedge clk);  // cycle 4
    checks++;
    if (if_ack !== 1'b0 || if_dout !== 32'h8880200a) begin
      errors++;
      $display("FAIL if_read_hold: if_ack=%b data=%h required 0 8880200a", if_ack, if_dout);
    end
  endtask

  task automatic test_dm_write();
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 32'd2051; dm_din = 32'hdeadbeef;
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_wr} !== 2'b01 || mem_addr !== 32'd2048 || mem_din !== 32'hdeadbeef) begin
      errors++;
      $display("FAIL dm_write_c1: rd/wr=%b addr=%0d din=%h required 01 2048 deadbeef", {mem_rd, mem_wr}, mem_addr, mem_din);
    end
    @(negedge clk);
    checks++;
    if (mem_wr !== 1'b1 || dm_ack !== 1'b0) begin
      errors++;
      $display("FAIL dm_write_c2: mem_wr=%b dm_ack=%b required 1 0", mem_wr, dm_ack);
    end
    @(negedge clk);
    checks++;
    if (dm_ack !== 1'b1 || if_ack !== 1'b0 || mem_wr !== 1'b0 || dm_dout !== 32'd0) begin
      errors++;
      $display("FAIL dm_write_ack: dm_ack=%b if_ack=%b wr=%b dm_dout=%h required 1 0 0 00000000", dm_ack, if_ack, mem_wr, dm_dout);
    end
    dm_req = 1'b0; dm_wr = 1'b0;
    @(negedge clk);
    checks++;
    if (dm_ack !== 1'b0) begin
      errors++;
      $display("FAIL dm_write_single_pulse: dm_ack=%b required 0", dm_ack);
    end
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'd2052;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 32'd2056;
    @(negedge clk);  // c1
    checks++;
    if (mem_addr !== 32'd2056 || mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL prio_first_owner: addr=%0d rd=%b required 2056 1", mem_addr, mem_rd);
    end
    repeat (2) @(negedge clk);  // c3
    checks++;
    if (dm_ack !== 1'b1 || if_ack !== 1'b0 || dm_dout !== 32'h88813fff) begin
      errors++;
      $display("FAIL prio_dm_ack: dm_ack=%b if_ack=%b dm_dout=%h required 1 0 88813fff", dm_ack, if_ack, dm_dout);
    end
    dm_req = 1'b0;
    repeat (2) @(negedge clk);  // c5
    checks++;
    if (mem_addr !== 32'd2052 || mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL prio_second_owner: addr=%0d rd=%b required 2052 1", mem_addr, mem_rd);
    end
    repeat (2) @(negedge clk);  // c7
    checks++;
    if (if_ack !== 1'b1 || dm_ack !== 1'b0 || if_dout !== 32'h86802000) begin
      errors++;
      $display("FAIL prio_if_ack: if_ack=%b dm_ack=%b if_dout=%h required 1 0 86802000", if_ack, dm_ack, if_dout);
    end
    if_req = 1'b0;
    @(negedge clk);  // c8, IDLE: third simultaneous round
    if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'd2060;
    @(negedge clk);  // c9
    checks++;
    if (mem_addr !== 32'd2060) begin
      errors++;
      $display("FAIL prio_third_owner: addr=%0d required 2060", mem_addr);
    end
    repeat (2) @(negedge clk);  // c11
    checks++;
    if (dm_ack !== 1'b1 || dm_dout !== 32'h82802001) begin
      errors++;
      $display("FAIL prio_third_ack: dm_ack=%b dm_dout=%h required 1 82802001", dm_ack, dm_dout);
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_rd, if_ack, dm_ack} !== 3'b000) begin
      errors++;
      $display("FAIL prio_idle: rd/if_ack/dm_ack=%b required 000", {mem_rd, if_ack, dm_ack});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_word;
    if_req = 1'b1; if_addr = 32'd2048;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      checks++;
      if (if_ack !== ((c % 4) == 3)) begin
        errors++;
        $display("FAIL b2b_ack_c%0d: if_ack=%b required %b", c, if_ack, ((c % 4) == 3));
      end
      if ((c % 4) == 3) begin
        exp_word = mem_word(32'd2048 + 32'(4 * (c / 4)));
        checks++;
        if (if_dout !== exp_word) begin
          errors++;
          $display("FAIL b2b_data_c%0d: if_dout=%h required %h", c, if_dout, exp_word);
        end
        if (c == 15) if_req = 1'b0;
        else         if_addr = if_addr + 32'd4;
      end
    end
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'd2060;
    repeat (2) @(negedge clk);  // c2, second ACCESS cycle
    checks++;
    if (mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_access: mem_rd=%b required 1", mem_rd);
    end
    rst = 1'b1;
    @(negedge clk);  // c3
    checks++;
    if (mem_rd !== 1'b0 || if_ack !== 1'b0 || if_dout !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_abort: rd=%b ack=%b if_dout=%h required 0 0 00000000", mem_rd, if_ack, if_dout);
    end
    rst = 1'b0;
    @(negedge clk);  // c4
    checks++;
    if (mem_rd !== 1'b1 || if_ack !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_restart: rd=%b ack=%b required 1 0", mem_rd, if_ack);
    end
    repeat (2) @(negedge clk);  // c6
    checks++;
    if (if_ack !== 1'b1 || if_dout !== 32'h82802001) begin
      errors++;
      $display("FAIL rstmid_complete: ack=%b if_dout=%h required 1 82802001", if_ack, if_dout);
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ws0_drop();
    if_req0 = 1'b1; if_addr0 = 32'd2056;
    @(negedge clk);  // c1
    checks++;
    if (mem_rd0 !== 1'b1 || mem_addr0 !== 32'd2056) begin
      errors++;
      $display("FAIL ws0_access: rd=%b addr=%0d required 1 2056", mem_rd0, mem_addr0);
    end
    if_req0 = 1'b0;
    @(negedge clk);  // c2
    checks++;
    if (if_ack0 !== 1'b1 || if_dout0 !== 32'h88813fff || {dm_ack0, mem_wr0, mem_rd0} !== 3'b000) begin
      errors++;
      $display("FAIL ws0_ack: ack=%b data=%h dm_ack/wr/rd=%b required 1 88813fff 000", if_ack0, if_dout0, {dm_ack0, mem_wr0, mem_rd0});
    end
    @(negedge clk);  // c3
    checks++;
    if (if_ack0 !== 1'b0 || mem_rd0 !== 1'b0) begin
      errors++;
      $display("FAIL ws0_idle: ack=%b rd=%b required 0 0", if_ack0, mem_rd0);
    end
    @(negedge clk);  // c4, dropped request must not restart
    checks++;
    if (mem_rd0 !== 1'b0 || if_dout0 !== 32'h88813fff) begin
      errors++;
      $display("FAIL ws0_no_restart: rd=%b data=%h required 0 88813fff", mem_rd0, if_dout0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_if_read();
    test_dm_write();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_ws0_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single-port main memory between two requesters: instruction fetch (IF, read-only) and data memory access (DM, read/write).
- Registers each request, drives the memory RD/WR/ADDRESS/DATA_IN strobes for a fixed wait-state window, captures DATA_OUT, and returns a one-cycle ACK to the winning requester.
- Sits between the processor control unit and the main memory module. One transaction is in flight at a time.

Parameters:
- DATAWIDTH_BUS, 32, width of address and data buses.
- WAIT_STATES, 1, extra cycles the memory strobes are held before data is sampled (0..15).

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- IF_REQ  input  1  fetch request; held until IF_ACK.
- IF_ADDRESS  input  DATAWIDTH_BUS  fetch byte address; stable while IF_REQ is high.
- IF_DATA_OUT  output  DATAWIDTH_BUS  fetched instruction word; valid when IF_ACK=1, held afterwards.
- IF_ACK  output  1  one-cycle completion pulse.
- DM_REQ  input  1  data request; held until DM_ACK.
- DM_WR  input  1  1=write, 0=read; stable while DM_REQ is high.
- DM_ADDRESS  input  DATAWIDTH_BUS  data byte address.
- DM_DATA_IN  input  DATAWIDTH_BUS  write data.
- DM_DATA_OUT  output  DATAWIDTH_BUS  read data; valid when DM_ACK=1, held afterwards.
- DM_ACK  output  1  one-cycle completion pulse.
- MEM_RD  output  1  memory read strobe.
- MEM_WR  output  1  memory write strobe.
- MEM_ADDRESS  output  DATAWIDTH_BUS  memory address, word-aligned.
- MEM_DATA_IN  output  DATAWIDTH_BUS  memory write data.
- MEM_DATA_OUT  input  DATAWIDTH_BUS  memory read data.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, all ACKs 0, MEM_RD=0, MEM_WR=0, MEM_ADDRESS=0, MEM_DATA_IN=0, IF_DATA_OUT=0, DM_DATA_OUT=0, wait counter=0, round-robin pointer=IF.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any REQ is high at the clock edge: select the winner, latch owner, address, write data and WR; load counter=WAIT_STATES; go to ACCESS.
  - Else stay in IDLE.
- ACCESS:
  - MEM_RD=~wr and MEM_WR=wr for the owner.
  - MEM_ADDRESS = latched address with bits [1:0] forced to 0.
  - Counter decrements each cycle. When the counter is 0, capture MEM_DATA_OUT into the owner's DATA_OUT (reads only; writes leave DATA_OUT unchanged), drop MEM_RD/MEM_WR, go to RESP.
  - ACCESS lasts WAIT_STATES+1 cycles.
- RESP:
  - The owner's ACK is high for exactly one cycle, then return to IDLE.
  - IF_ACK and DM_ACK are never high together.
- Latency and throughput:
  - REQ sampled at edge 0 -> ACK high in cycle WAIT_STATES+2.
  - Back-to-back transactions take WAIT_STATES+3 cycles each.
- Handshake:
  - A requester drops REQ in the cycle after ACK. If REQ is still high in IDLE, it is treated as a new request.
  - IF_REQ with IF write is not possible; IF is always a read.
- Priority (macro off): fixed priority, DM wins over IF on simultaneous requests.
- Requests arriving during ACCESS or RESP wait; they are sampled only in IDLE.
- REQ dropped mid-transaction: the transaction still completes and ACK still pulses. Latched inputs are not re-sampled.
- RESET mid-transaction: next state is IDLE, strobes drop the same edge, no ACK is issued, and the captured data is cleared to 0.
- Counter width is 4 bits; a WAIT_STATES value above 15 is an elaboration error.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN defined:
  - On simultaneous requests, grant the requester not served last. The pointer updates on entering ACCESS.
  - A single requester always wins regardless of the pointer.
- Undefined: fixed DM-over-IF priority, no pointer register.

Decomposition:
- Package mem_arb_pkg:
  - FSM state enum (IDLE, ACCESS, RESP).
  - Owner encoding (OWN_IF=0, OWN_DM=1).
  - Counter width constant.
- Sub-module mem_arb_grant: 2-way grant logic, plus the round-robin pointer under the macro. It takes IF_REQ/DM_REQ/enable and returns the grant owner and a valid flag.

Test Plan:
- IF_REQ=1, IF_ADDRESS=2048, memory returns 32'h8880200a, WAIT_STATES=1 -> MEM_RD high for 2 cycles, MEM_ADDRESS=2048, IF_ACK in cycle 3 with IF_DATA_OUT=32'h8880200a, DM_ACK=0.
- DM_REQ=1, DM_WR=1, DM_ADDRESS=2051, DM_DATA_IN=32'hdeadbeef -> MEM_WR high, MEM_ADDRESS=2048, MEM_DATA_IN=32'hdeadbeef, MEM_RD=0, DM_ACK pulses once, DM_DATA_OUT unchanged.
- IF_REQ and DM_REQ rise together, held for 2 transactions:
  - Macro off -> DM served first, then IF.
  - Macro on with pointer=IF -> DM first, then IF; a third simultaneous round goes to DM again.
- IF_REQ held for 4 transactions at 2048, 2052, 2056, 2060 -> IF_ACK every 4 cycles (WAIT_STATES=1), data 8880200a, 86802000, 88813fff, 82802001.
- RESET asserted in the second ACCESS cycle -> next cycle state=IDLE, MEM_RD=0, no ACK, IF_DATA_OUT=0; a fresh request afterwards completes normally.
- WAIT_STATES=0, IF_REQ dropped in ACCESS -> IF_ACK still pulses in cycle 2; arbiter is back in IDLE in cycle 3.
